// File: rtl/cla_serial_add_sched.sv
// cla_serial_add_sched -- two-requester scheduler around one shared 4-bit CLA slice.
// Round-robin arbitration picks an operation, which then runs nibble-serially
// (LSB nibble first) with a registered inter-nibble carry.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid/ready/a/b/sub      request channel per requester (N = 0, 1); sub=1 -> A-B
//   rsp_valid/ready               response handshake
//   rsp_id, rsp_sum               originating requester and WIDTH-bit result
//   rsp_cout, rsp_ovf             MSB carry-out (1 = no borrow on subtract), signed overflow
//   busy                          high while an operation is running or awaiting consumption

module cl_four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[3:0];
    cout = c[4];
  end
endmodule

module cla_serial_add_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic              last_grant_q, last_grant_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_sum_q, rsp_sum_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic              rsp_id_q, rsp_id_d;

  logic              grant;
  logic              accept;
  logic [3:0]        slice_a, slice_b, slice_s;
  logic              slice_cout;

  cl_four_bit_adder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    slice_a = op_a_q[4*int'(idx_q) +: 4];
    slice_b = op_b_q[4*int'(idx_q) +: 4];
  end

  // Ready is qualified with valid so an idle requester never sees a spurious accept.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
    req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
    req1_ready = rst_n && (state_q == IDLE) && req1_valid &&  grant;
    accept     = req0_ready || req1_ready;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_id_d     = rsp_id_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d   = grant ? req1_a : req0_a;
          op_b_d   = grant ? (req1_sub ? ~req1_b : req1_b) : (req0_sub ? ~req0_b : req0_b);
          carry_d  = grant ? req1_sub : req0_sub;
          rsp_id_d = grant;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        rsp_sum_d[4*int'(idx_q) +: 4] = slice_s;
        carry_d = slice_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(NIB - 1)) begin
          rsp_cout_d = slice_cout;
          rsp_ovf_d  = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (slice_s[3] != op_a_q[WIDTH-1]);
          state_d    = RESP;
        end
      end
      RESP: begin
        // Result is already complete on RESP entry; rsp_valid is raised one cycle
        // later, giving the fixed accept-to-valid latency of NIB+1 edges.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          last_grant_d = rsp_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  always_comb begin
    rsp_valid = rsp_valid_q;
    rsp_sum   = rsp_sum_q;
    rsp_cout  = rsp_cout_q;
    rsp_ovf   = rsp_ovf_q;
    rsp_id    = rsp_id_q;
    busy      = (state_q == RUN) || (state_q == RESP);
  end
endmodule
